// File: rtl/hit_input_conditioner.sv
// hit_input_conditioner
//   Conditions four raw, active-low target sensors into debounced levels,
//   one-cycle hit pulses and a single-entry-per-channel event stream for
//   the downstream scoring stage.
//
// Ports
//   clk        system clock, all state updates on its rising edge
//   reset      asynchronous, active-high reset
//   in1..in4   raw asynchronous sensors (0 = struck), channel 0..3
//   level      debounced sensor levels, bit i = channel i
//   hit        one-cycle pulse on each accepted debounced 1->0 transition
//   evt_valid  an event is offered downstream
//   evt_id     channel index of the offered event
//   evt_ready  downstream accepts the offered event
//   overflow   sticky: a hit was merged into an already-pending event
//
// Handshake: an event transfers on a rising edge where evt_valid=1 and
// evt_ready=1. While evt_valid=1 and evt_ready=0, evt_id is held stable.
// evt_valid never depends combinationally on evt_ready.
module hit_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  output logic [3:0] level,
  output logic [3:0] hit,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  input  logic       evt_ready,
  output logic       overflow
);

  // Wide enough to hold DEBOUNCE_CYCLES itself, so no wrap-around.
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  logic [3:0]          raw;
  logic [3:0]          meta_q;
  logic [3:0]          sync_q;
  logic [3:0][CW-1:0]  cnt_q;
  logic [3:0][CW-1:0]  cnt_d;
  logic [3:0]          level_q;
  logic [3:0]          level_d;
  logic [3:0]          hit_q;
  logic [3:0]          hit_d;
  logic [3:0]          pending_q;
  logic [3:0]          pending_d;
  logic [3:0]          clr_mask;
  logic                overflow_q;
  logic                overflow_d;
  state_t              state_q;
  state_t              state_d;
  logic [1:0]          evt_id_q;
  logic [1:0]          evt_id_d;

  assign raw = {in4, in3, in2, in1};

  // Lowest-index set bit; only called when at least one bit is set.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0])      lowest_set = 2'd0;
    else if (v[1]) lowest_set = 2'd1;
    else if (v[2]) lowest_set = 2'd2;
    else           lowest_set = 2'd3;
  endfunction

  // Debounce: count consecutive cycles where the synchronized input
  // disagrees with the accepted level; accept on the DEBOUNCE_CYCLES-th.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    hit_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = sync_q[i];
        // Only a falling (1->0) acceptance is a strike.
        hit_d[i]   = level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Event FSM plus pending bookkeeping. A hit on the channel being
  // accepted on the same edge re-arms pending as a fresh event, so the
  // overflow test masks out the bit being cleared.
  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          evt_id_d = lowest_set(pending_q);
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          clr_mask = 4'b0001 << evt_id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d  = (pending_q & ~clr_mask) | hit_d;
    overflow_d = overflow_q | (|(hit_d & pending_q & ~clr_mask));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q     <= 4'b1111;
      sync_q     <= 4'b1111;
      cnt_q      <= '0;
      level_q    <= 4'b1111;
      hit_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      evt_id_q   <= 2'd0;
    end else begin
      meta_q     <= raw;
      sync_q     <= meta_q;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      hit_q      <= hit_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      evt_id_q   <= evt_id_d;
    end
  end

  assign level     = level_q;
  assign hit       = hit_q;
  assign evt_valid = (state_q == OFFER);
  assign evt_id    = evt_id_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_hit_input_conditioner.sv
// tb_hit_input_conditioner
//   Directed bench for hit_input_conditioner with DEBOUNCE_CYCLES=4.
//   Inputs are driven 1 time unit after a rising edge and outputs are
//   checked 1 time unit after the following rising edge, so every "step"
//   is one sampling edge. A raw change first sampled on step k is
//   accepted into level on step k+5.
module tb_hit_input_conditioner;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in1 = 1'b1;
  logic       in2 = 1'b1;
  logic       in3 = 1'b1;
  logic       in4 = 1'b1;
  logic       evt_ready = 1'b0;
  logic [3:0] level;
  logic [3:0] hit;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  // Expected channel order of accepted events.
  logic [1:0] exp_q[$];
  logic [1:0] exp_id;

  typedef struct {
    logic [3:0] raw;
    logic       rdy;
    logic [3:0] lvl;
    logic [3:0] ht;
    logic       vld;
    logic [1:0] id;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  hit_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .level     (level),
    .hit       (hit),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .overflow  (overflow)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] raw, input logic rdy);
    in1 = raw[0];
    in2 = raw[1];
    in3 = raw[2];
    in4 = raw[3];
    evt_ready = rdy;
  endtask

  task automatic step(input logic [3:0] raw, input logic rdy);
    drive(raw, rdy);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] lvl, input logic [3:0] ht,
                         input logic vld, input logic [1:0] id, input logic ovf);
    chk({name, ".level"},     8'(level),     8'(lvl));
    chk({name, ".hit"},       8'(hit),       8'(ht));
    chk({name, ".evt_valid"}, 8'(evt_valid), 8'(vld));
    chk({name, ".evt_id"},    8'(evt_id),    8'(id));
    chk({name, ".overflow"},  8'(overflow),  8'(ovf));
  endtask

  task automatic run(input string name, input int n, input logic [3:0] raw, input logic rdy,
                     input logic [3:0] lvl, input logic [3:0] ht, input logic vld,
                     input logic [1:0] id, input logic ovf);
    for (int k = 0; k < n; k++) begin
      step(raw, rdy);
      chk_all($sformatf("%s[%0d]", name, k), lvl, ht, vld, id, ovf);
    end
  endtask

  // Asynchronous reset pulse; outputs must clear without a clock edge.
  task automatic do_reset(input string name, input logic [3:0] raw);
    drive(raw, 1'b0);
    reset = 1'b1;
    #1;
    chk_all({name, ".async"}, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all({name, ".held"}, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] raw, input logic rdy, input logic [3:0] lvl,
                              input logic [3:0] ht, input logic vld, input logic [1:0] id,
                              input logic ovf);
    vec_t v;
    v.raw = raw; v.rdy = rdy; v.lvl = lvl; v.ht = ht; v.vld = vld; v.id = id; v.ovf = ovf;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    // Single press on channel 0, accepted immediately, then release.
    for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b1110, 1, 4'b1111, 4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1110, 1, 4'b1110, 4'b0001, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1110, 1, 4'b1110, 4'b0000, 1, 2'd0, 0));
    tbl.push_back(mk(4'b1110, 1, 4'b1110, 4'b0000, 0, 2'd0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b1111, 1, 4'b1110, 4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 0));
    // Channel 1 bounce: low 3, high 1, low held -> one hit only.
    for (int k = 0; k < 3; k++) tbl.push_back(mk(4'b1101, 1, 4'b1111, 4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b1101, 1, 4'b1111, 4'b0000, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1101, 1, 4'b1101, 4'b0010, 0, 2'd0, 0));
    tbl.push_back(mk(4'b1101, 1, 4'b1101, 4'b0000, 1, 2'd1, 0));
    tbl.push_back(mk(4'b1101, 1, 4'b1101, 4'b0000, 0, 2'd1, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b1111, 1, 4'b1101, 4'b0000, 0, 2'd1, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd1, 0));

    // Reset state while held in reset.
    drive(4'b1111, 1'b1);
    @(posedge clk);
    #1;
    chk_all("reset_state", 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Quiet inputs: nothing happens.
    run("idle", 20, 4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 0);

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].raw, tbl[i].rdy);
      chk_all($sformatf("row%0d", i), tbl[i].lvl, tbl[i].ht, tbl[i].vld, tbl[i].id, tbl[i].ovf);
    end

    // Channels 2 and 3 strike together; lowest index offered first and held.
    run("dual_wait", 5, 4'b0011, 0, 4'b1111, 4'b0000, 0, 2'd1, 0);
    run("dual_hit",  1, 4'b0011, 0, 4'b0011, 4'b1100, 0, 2'd1, 0);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_id = exp_q.pop_front();
    run("dual_offer2", 11, 4'b0011, 0, 4'b0011, 4'b0000, 1, exp_id, 0);
    run("dual_acc2",   1, 4'b0011, 1, 4'b0011, 4'b0000, 0, exp_id, 0);
    exp_id = exp_q.pop_front();
    run("dual_offer3", 1, 4'b0011, 0, 4'b0011, 4'b0000, 1, exp_id, 0);
    run("dual_acc3",   1, 4'b0011, 1, 4'b0011, 4'b0000, 0, exp_id, 0);
    run("dual_empty",  1, 4'b0011, 0, 4'b0011, 4'b0000, 0, 2'd3, 0);
    run("dual_rel",    5, 4'b1111, 0, 4'b0011, 4'b0000, 0, 2'd3, 0);
    run("dual_rel_lv", 1, 4'b1111, 0, 4'b1111, 4'b0000, 0, 2'd3, 0);

    // Overflow: second press on channel 0 while its event is still pending.
    run("ovf_p1w",  5, 4'b1110, 0, 4'b1111, 4'b0000, 0, 2'd3, 0);
    run("ovf_p1h",  1, 4'b1110, 0, 4'b1110, 4'b0001, 0, 2'd3, 0);
    run("ovf_off",  1, 4'b1110, 0, 4'b1110, 4'b0000, 1, 2'd0, 0);
    run("ovf_relw", 5, 4'b1111, 0, 4'b1110, 4'b0000, 1, 2'd0, 0);
    run("ovf_rel",  1, 4'b1111, 0, 4'b1111, 4'b0000, 1, 2'd0, 0);
    run("ovf_p2w",  5, 4'b1110, 0, 4'b1111, 4'b0000, 1, 2'd0, 0);
    run("ovf_p2h",  1, 4'b1110, 0, 4'b1110, 4'b0001, 1, 2'd0, 1);
    run("ovf_acc",  1, 4'b1110, 1, 4'b1110, 4'b0000, 0, 2'd0, 1);
    run("ovf_none", 5, 4'b1110, 1, 4'b1110, 4'b0000, 0, 2'd0, 1);
    run("ovf_relw2",5, 4'b1111, 1, 4'b1110, 4'b0000, 0, 2'd0, 1);
    run("ovf_rel2", 1, 4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 1);

    // Reset mid-debounce: partial count discarded, overflow cleared.
    run("rst_db_pre", 3, 4'b0111, 1, 4'b1111, 4'b0000, 0, 2'd0, 1);
    do_reset("rst_db", 4'b1111);
    run("rst_db_post", 10, 4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 0);

    // Fresh count after reset, then reset mid-offer.
    run("rst_of_w", 5, 4'b0111, 0, 4'b1111, 4'b0000, 0, 2'd0, 0);
    run("rst_of_h", 1, 4'b0111, 0, 4'b0111, 4'b1000, 0, 2'd0, 0);
    run("rst_of_o", 1, 4'b0111, 0, 4'b0111, 4'b0000, 1, 2'd3, 0);
    do_reset("rst_of", 4'b1111);
    run("rst_of_post", 10, 4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 0);

    // New hit on the offered channel on its acceptance edge: fresh event,
    // no overflow.
    run("same_p1w", 5, 4'b1110, 0, 4'b1111, 4'b0000, 0, 2'd0, 0);
    run("same_p1h", 1, 4'b1110, 0, 4'b1110, 4'b0001, 0, 2'd0, 0);
    run("same_off", 1, 4'b1110, 0, 4'b1110, 4'b0000, 1, 2'd0, 0);
    run("same_rlw", 5, 4'b1111, 0, 4'b1110, 4'b0000, 1, 2'd0, 0);
    run("same_rl",  1, 4'b1111, 0, 4'b1111, 4'b0000, 1, 2'd0, 0);
    run("same_p2w", 5, 4'b1110, 0, 4'b1111, 4'b0000, 1, 2'd0, 0);
    run("same_p2h", 1, 4'b1110, 1, 4'b1110, 4'b0001, 0, 2'd0, 0);
    run("same_re",  1, 4'b1110, 0, 4'b1110, 4'b0000, 1, 2'd0, 0);
    run("same_acc", 1, 4'b1110, 1, 4'b1110, 4'b0000, 0, 2'd0, 0);
    run("same_end", 2, 4'b1110, 1, 4'b1110, 4'b0000, 0, 2'd0, 0);
    run("same_rw2", 5, 4'b1111, 1, 4'b1110, 4'b0000, 0, 2'd0, 0);
    run("same_r2",  1, 4'b1111, 1, 4'b1111, 4'b0000, 0, 2'd0, 0);

    // Input already low through reset release: debounced normally, one hit.
    do_reset("rst_low", 4'b1110);
    run("low_w",   5, 4'b1110, 0, 4'b1111, 4'b0000, 0, 2'd0, 0);
    run("low_h",   1, 4'b1110, 0, 4'b1110, 4'b0001, 0, 2'd0, 0);
    run("low_off", 1, 4'b1110, 0, 4'b1110, 4'b0000, 1, 2'd0, 0);
    run("low_acc", 1, 4'b1110, 1, 4'b1110, 4'b0000, 0, 2'd0, 0);
    run("low_end", 3, 4'b1110, 1, 4'b1110, 4'b0000, 0, 2'd0, 0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_input_conditioner.md
HIT_INPUT_CONDITIONER -- requirements
Module: hit_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), meaning consecutive stable synchronized cycles required to accept a level change; legal range 2 to 2^24-1.
REQ-002 clk  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset; asynchronous, active-high.
REQ-004 in1..in4  input  1 each  raw asynchronous target sensors, active-low (0 = struck); channel index 0..3 maps to in1..in4.
REQ-005 level  output  4  debounced sensor levels, bit i = channel i.
REQ-006 hit  output  4  one-cycle pulse per channel on each accepted debounced 1->0 transition.
REQ-007 evt_valid  output  1  a hit event is offered to the downstream scoring stage.
REQ-008 evt_id  output  2  channel index of the offered event.
REQ-009 evt_ready  input  1  downstream accepts the offered event.
REQ-010 overflow  output  1  sticky flag: a hit was merged into an already-pending event.

Function
REQ-011 Each channel SHALL pass its input through a 2-flop synchronizer; only the second flop output (sync) SHALL feed later logic.
REQ-012 Per channel, a counter SHALL increment each cycle sync differs from level[i] and SHALL clear to 0 in any cycle sync equals level[i].
REQ-013 When the counter would reach DEBOUNCE_CYCLES, level[i] SHALL take the sync value at that edge and the counter SHALL clear.
REQ-014 Latency: a raw change held steady SHALL update level[i] on the (DEBOUNCE_CYCLES+2)-th rising edge sampling the new value; any earlier reversion restarts the count.
REQ-015 hit[i] SHALL be 1 for exactly the cycle after the edge on which level[i] goes 1->0; a 0->1 update SHALL produce no hit and no event.
REQ-016 Each accepted hit SHALL set pending[i] on the same edge hit[i] is registered.
REQ-017 Event FSM has two states: IDLE (evt_valid=0) and OFFER (evt_valid=1).
REQ-018 IDLE: if any pending bit is set, load evt_id with the lowest-index set pending bit and enter OFFER; else stay IDLE.
REQ-019 OFFER: evt_id SHALL stay constant; on an edge with evt_ready=1, clear pending[evt_id] and return to IDLE; with evt_ready=0, hold.
REQ-020 Throughput is at most one event per 2 cycles; hit to evt_valid latency is exactly 1 cycle when the FSM is IDLE.
REQ-021 A new hit on channel i while pending[i]=1 and not being cleared on that edge SHALL keep pending[i]=1 and set overflow=1.
REQ-022 A new hit on channel evt_id on the same edge the event is accepted SHALL leave pending[i]=1 (a fresh event) without setting overflow.
REQ-023 Hits on multiple channels on the same edge SHALL each set their own pending bit; none SHALL be lost.
REQ-024 overflow SHALL clear only on reset.
REQ-025 Counters SHALL be sized to hold DEBOUNCE_CYCLES without wrap-around.

Reset
REQ-026 While reset=1: synchronizer flops=1, level=4'b1111, counters=0, hit=0, pending=0, FSM=IDLE, evt_valid=0, evt_id=0, overflow=0.
REQ-027 Reset asserted mid-debounce or mid-offer SHALL discard the partial count and any pending/offered event, with no hit or event after deassertion.
REQ-028 After deassertion, the first sync sample SHALL be available 2 edges later; an input already held low SHALL then be debounced normally and produce one hit.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, inputs high, evt_ready=1 for 20 cycles -> level=1111, hit=0, evt_valid=0, overflow=0 throughout.
REQ-030 in1 low from edge 0, held -> level[0]=0 and hit=0001 for one cycle after edge 5; evt_valid=1, evt_id=0 after edge 6; evt_ready=1 -> evt_valid=0 after edge 7.
REQ-031 in2 low 3 cycles, high 1 cycle, then low held -> exactly one hit[1], 6 edges after the final fall; no hit during the bounce.
REQ-032 in3 and in4 fall on the same edge, evt_ready=0 -> evt_id=2 held stable 10 cycles; one-cycle evt_ready -> IDLE, then evt_id=3 offered.
REQ-033 evt_ready=0; in1 press, release, press again -> second hit[0] sets overflow=1; after one acceptance, no further event for channel 0.
REQ-034 in4 low 3 cycles, then reset pulse, then in4 high -> no hit, no event, counters 0.
